multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control finite-state machine for the multi-cycle MIPS datapath. It decodes the instruction opcode and funct field from the instruction register. Each cycle it drives the datapath strobes, mux selects and the 4-bit `ALUOp` consumed by the ALU control decoder. It waits on a memory-ready handshake during instruction fetch and during data loads and stores.

## Interface
- Parameters: none.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; forces state to FETCH.
- `Op`  in  6  opcode, `IR[31:26]`; stable from the cycle after IRWrite.
- `Funct`  in  6  `IR[5:0]`.
- `memReady`  in  1  memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath strobes/selects.
- `ALUSrcB`  out  2  selects: 0 = reg B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `PCSource`  out  2  selects: 0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = reg A (jr).
- `ALUOp`  out  4  encodings: 0 = add, 1 = sub, 2 = R-type funct, 3 = addi, 4 = slti.
- `state`  out  4  current state, for debug.
- `instrDone`  out  1  one-cycle pulse on the last cycle of each instruction.
- `illegalOp`  out  1  one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- State is a 4-bit register. All outputs are combinational from `state`, `Op`, `Funct` and `memReady`. Any strobe not listed for a state is 0; its selects are 0.
- Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, REX 6, RWB 7, BRANCH 8, JUMP 9, IEX 10, IWB 11, JR 12. Codes 13–15 go to FETCH next cycle with all strobes 0.
- FETCH: `MemRead`=1, `ALUSrcB`=1, `ALUOp`=0. `IRWrite`=`PCWrite`=`memReady`. Stay while `memReady`=0, else go to DECODE.
- DECODE: `ALUSrcB`=3, `ALUOp`=0 (branch target into ALUOut). Next state by `Op`:
  - 35 (lw) or 43 (sw) → MEMADR.
  - 0 (R-type) → REX, except `Funct`=8 → JR.
  - 4 (beq) → BRANCH.
  - 2 (j) → JUMP.
  - 8 (addi) or 10 (slti) → IEX.
  - Anything else → FETCH, with `illegalOp`=1 and `instrDone`=1.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=0. Go to MEMREAD if `Op`=35, else MEMWRITE.
- MEMREAD: `MemRead`=1, `IorD`=1. Stay until `memReady`, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0, `instrDone`=1. Go to FETCH.
- MEMWRITE: `MemWrite`=1, `IorD`=1. Stay until `memReady`; then `instrDone`=1 and go to FETCH.
- REX: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=2. Go to RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `instrDone`=1. Go to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUOp`=1, `PCWriteCond`=1, `PCSource`=1, `instrDone`=1. Go to FETCH.
- JUMP: `PCWrite`=1, `PCSource`=2, `instrDone`=1. Go to FETCH.
- JR: `PCWrite`=1, `PCSource`=3, `instrDone`=1. Go to FETCH.
- IEX: `ALUSrcA`=1, `ALUSrcB`=2. `ALUOp`=3 if `Op`=8, else 4. Go to IWB.
- IWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0, `instrDone`=1. Go to FETCH.

## Timing
- Reset: on any clock edge with `reset`=1, state becomes FETCH, overriding every transition, including mid-wait. The cycle after reset presents FETCH outputs: `MemRead`=1, `ALUSrcB`=1, all other strobes 0. While `reset` is held, the state register stays 0.
- Cycle counts with `memReady` always 1:
  - lw 5.
  - sw, R-type, addi, slti 4.
  - beq, j, jr 3.
  - Illegal opcode 2.
- Each cycle with `memReady`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes stay constant during the wait.
- `IRWrite`, `PCWrite` in FETCH and `instrDone` in MEMWRITE are asserted only in the `memReady` cycle, so each write occurs exactly once per access.
- `instrDone` is high exactly once per instruction.

## Test plan
- Reset, then `memReady`=1, `Op`=0, `Funct`=32 → states 0,1,6,7,0. `ALUOp`=2 in REX. `RegWrite`=`RegDst`=1 in RWB. One `instrDone` pulse.
- lw (`Op`=35) with `memReady` low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. `IorD`=1 throughout MEMREAD. `MemtoReg`=1 in MEMWB.
- beq (`Op`=4) → 3 cycles. `ALUOp`=1, `PCWriteCond`=1, `PCSource`=1 in BRANCH. `ALUSrcB`=3 in DECODE.
- addi (`Op`=8) then slti (`Op`=10) → `ALUOp`=3 and then 4 in IEX. `ALUSrcB`=2. 4 cycles each.
- `Op`=0 with `Funct`=8 → JR, `PCSource`=3. `Op`=63 → `illegalOp` pulse, then back to FETCH.
- `reset` asserted in MEMWRITE while `memReady`=0 → FETCH on the next edge. `MemWrite`=0 and no `instrDone` pulse.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: decodes Op/Funct and
// sequences datapath strobes, mux selects and ALUOp, stalling on memReady.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       memReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic [3:0] state,
  output logic       instrDone,
  output logic       illegalOp
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_REX      = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IEX      = 4'd10,
    S_IWB      = 4'd11,
    S_JR       = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;

  state_t state_r;
  state_t next_state_s;

  assign state = state_r;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; everything not driven in a state stays 0.
  always_comb begin
    next_state_s = S_FETCH;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'd0;
    PCSource     = 2'd0;
    ALUOp        = 4'd0;
    instrDone    = 1'b0;
    illegalOp    = 1'b0;

    case (state_r)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        // IR and PC are written only on the completing cycle of the fetch.
        IRWrite = memReady;
        PCWrite = memReady;
        if (memReady) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        case (Op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE: begin
            if (Funct == FN_JR) begin
              next_state_s = S_JR;
            end else begin
              next_state_s = S_REX;
            end
          end
          OP_BEQ:           next_state_s = S_BRANCH;
          OP_J:             next_state_s = S_JUMP;
          OP_ADDI, OP_SLTI: next_state_s = S_IEX;
          default: begin
            next_state_s = S_FETCH;
            illegalOp    = 1'b1;
            instrDone    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        if (Op == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (memReady) begin
          next_state_s = S_MEMWB;
        end else begin
          next_state_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        instrDone = memReady;
        if (memReady) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_REX: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 4'd2;
        next_state_s = S_RWB;
      end
      S_RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 4'd1;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        instrDone   = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'd2;
        instrDone = 1'b1;
      end
      S_JR: begin
        PCWrite   = 1'b1;
        PCSource  = 2'd3;
        instrDone = 1'b1;
      end
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        if (Op == OP_ADDI) begin
          ALUOp = 4'd3;
        end else begin
          ALUOp = 4'd4;
        end
        next_state_s = S_IWB;
      end
      S_IWB: begin
        RegWrite  = 1'b1;
        instrDone = 1'b1;
      end
      default: begin
        // Unused codes 13-15 fall back to FETCH with all strobes low.
        next_state_s = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed test-plan sequences
// followed by random instructions checked against an instruction-level model.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       memReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, state;
  logic       instrDone, illegalOp;

  int passed = 0;
  int total  = 0;
  int done_cnt;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .instrDone(instrDone), .illegalOp(illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] dut_vec;
  assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
                    ALUOp, state, instrDone, illegalOp};

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd2) || (op == 6'd4) || (op == 6'd8) ||
           (op == 6'd10) || (op == 6'd35) || (op == 6'd43);
  endfunction

  // Phase sequence of one instruction, from the opcode's documented path.
  function automatic void build_path(input logic [5:0] op, input logic [5:0] fn,
                                     output int p[$]);
    p = {0, 1};
    case (op)
      6'd35:        p = {p, 2, 3, 4};
      6'd43:        p = {p, 2, 5};
      6'd0:         p = (fn == 6'd8) ? {p, 12} : {p, 6, 7};
      6'd4:         p = {p, 8};
      6'd2:         p = {p, 9};
      6'd8, 6'd10:  p = {p, 10, 11};
      default:      p = p;
    endcase
  endfunction

  // Expected output vector for a phase, from the per-state strobe listing.
  function automatic logic [23:0] expect_vec(input int st, input logic [5:0] op,
                                             input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, dn, ill;
    logic [1:0] asb, pcs;
    logic [3:0] aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, dn, ill} = 12'd0;
    asb = 2'd0; pcs = 2'd0; aop = 4'd0;
    case (st)
      0:  begin mrd = 1'b1; asb = 2'd1; irw = mr; pcw = mr; end
      1:  begin asb = 2'd3; ill = !is_legal(op); dn = !is_legal(op); end
      2:  begin asa = 1'b1; asb = 2'd2; end
      3:  begin mrd = 1'b1; iord = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
      5:  begin mwr = 1'b1; iord = 1'b1; dn = mr; end
      6:  begin asa = 1'b1; aop = 4'd2; end
      7:  begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
      8:  begin asa = 1'b1; aop = 4'd1; pcwc = 1'b1; pcs = 2'd1; dn = 1'b1; end
      9:  begin pcw = 1'b1; pcs = 2'd2; dn = 1'b1; end
      10: begin asa = 1'b1; asb = 2'd2; aop = (op == 6'd8) ? 4'd3 : 4'd4; end
      11: begin rw = 1'b1; dn = 1'b1; end
      12: begin pcw = 1'b1; pcs = 2'd3; dn = 1'b1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, asb, pcs, aop,
            st[3:0], dn, ill};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Drive one cycle at the given phase, check all outputs, then clock.
  task automatic step(input int st, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr);
    Op = op; Funct = fn; memReady = mr;
    #1;
    check($sformatf("op%0d_st%0d_mr%0d", op, st, mr), dut_vec, expect_vec(st, op, mr));
    if (instrDone === 1'b1) done_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run a whole instruction with the given number of memReady-low cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_waits, input int mem_waits);
    int p[$];
    build_path(op, fn, p);
    done_cnt = 0;
    foreach (p[i]) begin
      int w;
      w = (p[i] == 0) ? fetch_waits : ((p[i] == 3 || p[i] == 5) ? mem_waits : 0);
      for (int k = 0; k < w; k++) step(p[i], op, fn, 1'b0);
      if (p[i] == 0 || p[i] == 3 || p[i] == 5) step(p[i], op, fn, 1'b1);
      else step(p[i], op, fn, 1'($urandom_range(0, 1)));
    end
    total++;
    assert (done_cnt == 1) passed++;
    else $error("FAIL done_count op%0d observed=%0d expected=1", op, done_cnt);
  endtask

  logic [5:0] op_tbl [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd10, 6'd0};

  initial begin
    reset = 1'b1; Op = 6'd0; Funct = 6'd0; memReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset held: state stays in FETCH with fetch strobes.
    #1 check("reset_held", dut_vec, expect_vec(0, 6'd0, 1'b0));
    reset = 1'b0;
    @(negedge clk);

    run_instr(6'd0, 6'd32, 0, 0);   // R-type add
    run_instr(6'd35, 6'd0, 0, 2);   // lw, two stall cycles in MEMREAD
    run_instr(6'd4, 6'd0, 0, 0);    // beq
    run_instr(6'd8, 6'd0, 0, 0);    // addi
    run_instr(6'd10, 6'd0, 0, 0);   // slti
    run_instr(6'd0, 6'd8, 0, 0);    // jr
    run_instr(6'd63, 6'd0, 0, 0);   // illegal
    run_instr(6'd2, 6'd0, 1, 0);    // j with a fetch stall
    run_instr(6'd43, 6'd0, 2, 1);   // sw with stalls

    // Reset during a stalled MEMWRITE abandons the store.
    done_cnt = 0;
    step(0, 6'd43, 6'd0, 1'b1);
    step(1, 6'd43, 6'd0, 1'b1);
    step(2, 6'd43, 6'd0, 1'b1);
    step(5, 6'd43, 6'd0, 1'b0);
    reset = 1'b1; memReady = 1'b0;
    #1 check("memwrite_before_reset", dut_vec, expect_vec(5, 6'd43, 1'b0));
    @(posedge clk);
    @(negedge clk);
    #1 check("after_reset_in_memwrite", dut_vec, expect_vec(0, 6'd43, 1'b0));
    total++;
    assert (done_cnt == 0) passed++;
    else $error("FAIL aborted_store_done observed=%0d expected=0", done_cnt);
    reset = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tbl[$urandom_range(0, 7)];
      fn = ($urandom_range(0, 3) == 0) ? 6'd8 : 6'($urandom);
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
